// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: opcodes, adder source selects and
// the fetch/execute state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode into register strobes, adder source and
// control-flow flags. The parent gates everything with the EXEC state.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       load_a_o,
  output logic       load_b_o,
  output logic       load_out_o,
  output logic [1:0] sel_o,
  output logic       is_add_o,
  output logic       is_jmp_o,
  output logic       is_jnc_o
);

  always_comb begin
    load_a_o   = 1'b0;
    load_b_o   = 1'b0;
    load_out_o = 1'b0;
    sel_o      = SEL_ZERO;
    is_add_o   = 1'b0;
    is_jmp_o   = 1'b0;
    is_jnc_o   = 1'b0;
    case (opcode_i)
      OP_ADD_A: begin
        load_a_o = 1'b1;
        sel_o    = SEL_A;
        is_add_o = 1'b1;
      end
      OP_MOV_AB: begin
        load_a_o = 1'b1;
        sel_o    = SEL_B;
      end
      OP_IN_A: begin
        load_a_o = 1'b1;
        sel_o    = SEL_IN;
      end
      OP_MOV_AI: begin
        load_a_o = 1'b1;
        sel_o    = SEL_ZERO;
      end
      OP_MOV_BA: begin
        load_b_o = 1'b1;
        sel_o    = SEL_A;
      end
      OP_ADD_B: begin
        load_b_o = 1'b1;
        sel_o    = SEL_B;
        is_add_o = 1'b1;
      end
      OP_IN_B: begin
        load_b_o = 1'b1;
        sel_o    = SEL_IN;
      end
      OP_MOV_BI: begin
        load_b_o = 1'b1;
        sel_o    = SEL_ZERO;
      end
      OP_OUT_B: begin
        load_out_o = 1'b1;
        sel_o      = SEL_B;
      end
      OP_OUT_IM: begin
        load_out_o = 1'b1;
        sel_o      = SEL_ZERO;
      end
      OP_JNC:  is_jnc_o = 1'b1;
      OP_JMP:  is_jmp_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer of the 4-bit CPU: owns PC, IR and the carry flag
// and issues the one-cycle register load strobes during EXEC.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic       clk_cpu,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] rom_data,
  input  logic       alu_carry,
  output logic [3:0] rom_addr,
  output logic       load_a,
  output logic       load_b,
  output logic       load_out,
  output logic [1:0] sel,
  output logic [3:0] imm,
  output logic       carry,
  output logic [3:0] pc
);

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       carry_q, carry_d;

  logic       dec_load_a, dec_load_b, dec_load_out;
  logic [1:0] dec_sel;
  logic       dec_is_add, dec_is_jmp, dec_is_jnc;
  logic       in_exec;

  instr_decoder u_decoder (
    .opcode_i   (ir_q[7:4]),
    .load_a_o   (dec_load_a),
    .load_b_o   (dec_load_b),
    .load_out_o (dec_load_out),
    .sel_o      (dec_sel),
    .is_add_o   (dec_is_add),
    .is_jmp_o   (dec_is_jmp),
    .is_jnc_o   (dec_is_jnc)
  );

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= 4'd0;
      ir_q    <= 8'h00;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    case (state_q)
      ST_FETCH: begin
        if (run) begin
          ir_d    = rom_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        // JNC looks at the carry left by the previous instruction.
        if (dec_is_jmp || (dec_is_jnc && !carry_q)) begin
          pc_d = ir_q[3:0];
        end else begin
          pc_d = pc_q + 4'd1;
        end
        carry_d = dec_is_add ? alu_carry : 1'b0;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Strobes follow state_q directly so an asynchronous reset drops them at once.
  assign in_exec  = (state_q == ST_EXEC);
  assign load_a   = in_exec & dec_load_a;
  assign load_b   = in_exec & dec_load_b;
  assign load_out = in_exec & dec_load_out;
  assign sel      = in_exec ? dec_sel : SEL_ZERO;
  assign imm      = ir_q[3:0];
  assign carry    = carry_q;
  assign pc       = pc_q;
  assign rom_addr = pc_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a bench-side combinational ROM feeds the
// sequencer and each step checks strobes, sel, imm, pc and carry.
module tb_cpu_sequencer;

  logic       clk_cpu;
  logic       reset;
  logic       run;
  logic [7:0] rom_data;
  logic       alu_carry;
  logic [3:0] rom_addr;
  logic       load_a, load_b, load_out;
  logic [1:0] sel;
  logic [3:0] imm;
  logic       carry;
  logic [3:0] pc;

  logic [7:0] rom [16];
  int checks = 0;
  int errors = 0;

  assign rom_data = rom[rom_addr];

  cpu_sequencer dut (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .run       (run),
    .rom_data  (rom_data),
    .alu_carry (alu_carry),
    .rom_addr  (rom_addr),
    .load_a    (load_a),
    .load_b    (load_b),
    .load_out  (load_out),
    .sel       (sel),
    .imm       (imm),
    .carry     (carry),
    .pc        (pc)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strobes packed as {load_a, load_b, load_out}
  function automatic logic [7:0] strb();
    return {5'd0, load_a, load_b, load_out};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0]    = 8'h35;
    reset     = 1'b1;
    run       = 1'b0;
    alu_carry = 1'b0;
    tick();
    tick();
    chk("rst_pc", {4'd0, pc}, 8'h00);
    chk("rst_addr", {4'd0, rom_addr}, 8'h00);
    chk("rst_carry", {7'd0, carry}, 8'h00);
    chk("rst_strb", strb(), 8'h00);
    chk("rst_sel", {6'd0, sel}, 8'h03);
    chk("rst_imm", {4'd0, imm}, 8'h00);

    // reset in the middle of EXEC of MOV A,5
    reset = 1'b0;
    run   = 1'b1;
    tick();
    chk("mov5_load_a", strb(), 8'h04);
    chk("mov5_imm", {4'd0, imm}, 8'h05);
    #2 reset = 1'b1;
    #1;
    chk("midrst_strb", strb(), 8'h00);
    chk("midrst_sel", {6'd0, sel}, 8'h03);
    chk("midrst_pc", {4'd0, pc}, 8'h00);
    chk("midrst_imm", {4'd0, imm}, 8'h00);
    chk("midrst_carry", {7'd0, carry}, 8'h00);
    run = 1'b0;
    tick();
    reset = 1'b0;
    rom[0] = 8'h37;
    rom[1] = 8'h09;
    rom[2] = 8'hE0;
    rom[3] = 8'hE0;
    tick();
    chk("idle_strb", strb(), 8'h00);
    run = 1'b1;

    // MOV A,7 then ADD A,9 with adder carry out
    tick();
    chk("c1_strb", strb(), 8'h04);
    chk("c1_sel", {6'd0, sel}, 8'h03);
    chk("c1_imm", {4'd0, imm}, 8'h07);
    chk("c1_addr", {4'd0, rom_addr}, 8'h00);
    tick();
    chk("c2_strb", strb(), 8'h00);
    chk("c2_pc", {4'd0, pc}, 8'h01);
    alu_carry = 1'b1;
    tick();
    chk("c3_strb", strb(), 8'h04);
    chk("c3_sel", {6'd0, sel}, 8'h00);
    chk("c3_imm", {4'd0, imm}, 8'h09);
    tick();
    chk("c4_pc", {4'd0, pc}, 8'h02);
    chk("c4_carry", {7'd0, carry}, 8'h01);

    // JNC 0 with carry set: falls through and clears carry
    tick();
    chk("jnc1_strb", strb(), 8'h00);
    chk("jnc1_sel", {6'd0, sel}, 8'h03);
    tick();
    chk("jnc1_pc", {4'd0, pc}, 8'h03);
    chk("jnc1_carry", {7'd0, carry}, 8'h00);
    // JNC 0 with carry clear: taken
    tick();
    tick();
    chk("jnc2_pc", {4'd0, pc}, 8'h00);

    rom[0]  = 8'h0F;
    rom[1]  = 8'h85;
    rom[2]  = 8'hBB;
    rom[3]  = 8'hFF;
    rom[15] = 8'h8A;
    tick();
    chk("addf_strb", strb(), 8'h04);
    chk("addf_sel", {6'd0, sel}, 8'h00);
    tick();
    chk("addf_carry", {7'd0, carry}, 8'h01);
    chk("addf_pc", {4'd0, pc}, 8'h01);

    // undefined opcode 0x8 acts as NOP and clears carry
    tick();
    chk("nop_strb", strb(), 8'h00);
    chk("nop_sel", {6'd0, sel}, 8'h03);
    tick();
    chk("nop_pc", {4'd0, pc}, 8'h02);
    chk("nop_carry", {7'd0, carry}, 8'h00);

    // OUT Im 0xB
    tick();
    chk("out_strb", strb(), 8'h01);
    chk("out_sel", {6'd0, sel}, 8'h03);
    chk("out_imm", {4'd0, imm}, 8'h0B);
    tick();
    chk("out_after_strb", strb(), 8'h00);
    chk("out_pc", {4'd0, pc}, 8'h03);

    // JMP 15 then NOP at 15 wraps to 0
    tick();
    chk("jmp_strb", strb(), 8'h00);
    tick();
    chk("jmp_pc", {4'd0, pc}, 8'h0F);
    chk("jmp_addr", {4'd0, rom_addr}, 8'h0F);
    tick();
    tick();
    chk("wrap_pc", {4'd0, pc}, 8'h00);

    // run=0 in FETCH: nothing moves even though ROM now shows a new opcode
    run    = 1'b0;
    rom[0] = 8'h72;
    rom[1] = 8'h53;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_pc", {4'd0, pc}, 8'h00);
      chk("hold_strb", strb(), 8'h00);
      chk("hold_imm", {4'd0, imm}, 8'h0A);
      chk("hold_carry", {7'd0, carry}, 8'h00);
    end

    // run dropped during EXEC: MOV B,2 still completes, then hold
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("movb_strb", strb(), 8'h02);
    chk("movb_sel", {6'd0, sel}, 8'h03);
    chk("movb_imm", {4'd0, imm}, 8'h02);
    tick();
    chk("drop_pc", {4'd0, pc}, 8'h01);
    chk("drop_strb", strb(), 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drop_hold_pc", {4'd0, pc}, 8'h01);
      chk("drop_hold_strb", strb(), 8'h00);
    end

    // ADD B,3 selects B and captures carry
    run       = 1'b1;
    alu_carry = 1'b1;
    tick();
    chk("addb_strb", strb(), 8'h02);
    chk("addb_sel", {6'd0, sel}, 8'h01);
    tick();
    chk("addb_pc", {4'd0, pc}, 8'h02);
    chk("addb_carry", {7'd0, carry}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Fetch/decode/control unit of the 4-bit CPU. It owns the program counter, instruction register and carry flag. It fetches one 8-bit instruction per two-cycle step from the program ROM and drives the one-cycle `load` strobes, source-select and immediate that the datapath registers (A, B, OUT) and adder consume. It is the write-side controller for the register instances: every register `load` in the CPU originates here.

## Interface
Parameters:
- none (widths are fixed by the 4-bit ISA)

Ports:
- `clk_cpu`  in  1  CPU clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high; clock clk_cpu
- `run`  in  1  1 = execute; 0 = hold in FETCH, no state change
- `rom_data`  in  8  instruction at `rom_addr`; combinational ROM, valid same cycle
- `alu_carry`  in  1  carry-out of the datapath adder (mux source + imm)
- `rom_addr`  out  4  equals PC
- `load_a`, `load_b`, `load_out`  out  1 each  register write strobes
- `sel`  out  2  adder source: 00 = A, 01 = B, 10 = IN port, 11 = zero
- `imm`  out  4  always IR[3:0]
- `carry`  out  1  current carry flag
- `pc`  out  4  program counter (debug)

## Operation
- Two states: FETCH and EXEC.
  - FETCH: on the edge with `run=1`, IR <= `rom_data` and state -> EXEC. With `run=0` it stays in FETCH and nothing changes.
  - EXEC: decode IR[7:4] and assert the strobes below for exactly this cycle. On the edge, update PC and carry, then state -> FETCH unconditionally; `run` is ignored in EXEC.
- Opcodes, as IR[7:4] -> strobe, sel:
  - 0000 ADD A,Im -> load_a, sel A
  - 0001 MOV A,B -> load_a, sel B
  - 0010 IN A -> load_a, sel IN
  - 0011 MOV A,Im -> load_a, sel zero
  - 0100 MOV B,A -> load_b, sel A
  - 0101 ADD B,Im -> load_b, sel B
  - 0110 IN B -> load_b, sel IN
  - 0111 MOV B,Im -> load_b, sel zero
  - 1001 OUT B -> load_out, sel B
  - 1011 OUT Im -> load_out, sel zero
  - 1110 JNC Im -> no strobe
  - 1111 JMP Im -> no strobe
  - all other opcodes -> NOP, no strobe
- At most one `load_*` is high in any cycle. All strobes are 0 in FETCH.
- `sel` = 11 (zero) whenever no strobe is active.
- PC update at the end of EXEC:
  - JMP: PC <= IR[3:0]
  - JNC: PC <= IR[3:0] if carry = 0, else PC + 1
  - otherwise: PC + 1, modulo 16 (15 -> 0)
- Carry update at the end of EXEC:
  - ADD A,Im and ADD B,Im: carry <= `alu_carry`
  - every other opcode, including NOP and jumps: carry <= 0
  - JNC tests the carry value from before this update.

## Timing
- Throughput: one instruction per 2 clk_cpu cycles while `run=1`.
- Strobe latency: `load_*` is high in the cycle right after the fetch edge. The target register captures data on the edge that ends EXEC.
- `rom_addr` holds stable for the whole FETCH and EXEC pair. The new PC is visible in the next FETCH cycle.
- Reset (asynchronous, any state, including mid-EXEC) forces:
  - PC = 0, IR = 0x00, carry = 0, state = FETCH
  - all strobes 0, sel = 11
  - No partial instruction completes; any strobe deasserts immediately.
- Reset release: the first fetch is from address 0 on the first edge with `run=1`.
- Dropping `run` during EXEC does not abort the instruction. The instruction completes and the block then holds in FETCH.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (OP_ADD_A … OP_JMP)
  - `sel` encodings (SEL_A, SEL_B, SEL_IN, SEL_ZERO)
  - the state enum (ST_FETCH, ST_EXEC)
- One natural sub-module, `instr_decoder`. It is purely combinational: opcode -> {load_a, load_b, load_out, sel, is_add, is_jmp, is_jnc}. It is gated by `state == EXEC` in the parent.
- PC, IR, carry and state live in `cpu_sequencer`.

## Test plan
- Reset mid-EXEC of 0x35 (MOV A,5) -> `load_a` drops asynchronously; pc=0, carry=0, sel=11; next fetch is from address 0.
- ROM[0]=0x37 (MOV A,7), ROM[1]=0x09 (ADD A,9), `alu_carry`=1 on the ADD -> `load_a` pulses in cycles 1 and 3 with sel 11 then 00, imm 7 then 9; carry=1 after cycle 3; pc=2.
- Carry=1 then JNC 0x0 at address 2 (0xE0) -> no branch, pc=3, carry=0. Repeat the JNC with carry=0 -> pc=0.
- JMP 0xF (0xFF) followed by NOP at 15 -> pc goes 15 then wraps to 0.
- `run`=0 held 5 cycles in FETCH -> pc, IR, carry unchanged and no strobes. `run` dropped during EXEC -> instruction completes, then holds.
- OUT Im 0xB (0xBB) and undefined opcode 0x8x -> `load_out` pulses once with sel 11 and imm B. 0x8x produces no strobe, pc increments by 1, carry=0.
